// File: rtl/seg_scan.sv
// -----------------------------------------------------------------------------
// seg_scan: time-multiplexed driver for DIGITS common-cathode 7-segment digits.
//
// Each digit owns a slot of DIV clock cycles. The first GAP cycles of a slot
// are blank (all com off) to stop ghosting between digits. The remaining
// cycles drive one-hot com and the decoded segments for that digit. Loaded
// data waits in a pending register and reaches the displayed shadow register
// only at a frame boundary (or while idle), so a frame never shows a mix of
// old and new digits.
//
// Parameters:
//   DIGITS  number of digits scanned (>= 1)
//   DIV     clock cycles per digit slot (> GAP)
//   GAP     blank cycles at the start of each slot (0 = no gap)
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   en          scan enable; low blanks the display and parks the scanner
//   load        capture request for din / dp_in
//   din         BCD nibbles, din[3:0] is digit 0 (rightmost)
//   dp_in       decimal point per digit, 1 = lit
//   seg         {a,b,c,d,e,f,g,dp}, active-high, registered
//   com         one-hot digit select, active-high, registered
//   frame_done  one-cycle pulse after the edge on which the last slot ends
//
// Build option:
//   SEG_HEX_EN  when defined, codes 10-15 show A b C d E F; otherwise blank.
// -----------------------------------------------------------------------------
module seg_scan #(
  parameter int DIGITS = 4,
  parameter int DIV    = 1000,
  parameter int GAP    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     com,
  output logic                  frame_done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] GAP_C    = CNT_W'(GAP);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GAP  = 2'd1;
  localparam logic [1:0] ST_SHOW = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [4*DIGITS-1:0] pend_din_q, pend_din_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [4*DIGITS-1:0] shadow_din_q, shadow_din_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   com_q, com_d;
  logic                frame_done_q, frame_done_d;

  logic slot_end;
  logic wrap;
  logic frame_edge;

  // Segment pattern {a,b,c,d,e,f,g} for one code.
  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'd0:    pat = 7'b1111110;
      4'd1:    pat = 7'b0110000;
      4'd2:    pat = 7'b1101101;
      4'd3:    pat = 7'b1111001;
      4'd4:    pat = 7'b0110011;
      4'd5:    pat = 7'b1011011;
      4'd6:    pat = 7'b1011111;
      4'd7:    pat = 7'b1110000;
      4'd8:    pat = 7'b1111111;
      4'd9:    pat = 7'b1111011;
`ifdef SEG_HEX_EN
      4'd10:   pat = 7'b1110111;
      4'd11:   pat = 7'b0011111;
      4'd12:   pat = 7'b1001110;
      4'd13:   pat = 7'b0111101;
      4'd14:   pat = 7'b1001111;
      4'd15:   pat = 7'b1000111;
`endif
      default: pat = 7'b0000000;
    endcase
    return pat;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    pend_din_d   = pend_din_q;
    pend_dp_d    = pend_dp_q;
    shadow_din_d = shadow_din_q;
    shadow_dp_d  = shadow_dp_q;
    seg_d        = 8'd0;
    com_d        = '0;

    slot_end   = (state_q != ST_IDLE) && (cnt_q == CNT_LAST);
    wrap       = en && slot_end && (idx_q == IDX_LAST);
    frame_edge = wrap || (state_q == ST_IDLE);

    if (load) begin
      pend_din_d = din;
      pend_dp_d  = dp_in;
    end

    // A load on the boundary edge itself goes straight to the shadow.
    if (frame_edge) begin
      shadow_din_d = load ? din   : pend_din_q;
      shadow_dp_d  = load ? dp_in : pend_dp_q;
    end

    if (!en) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      if (state_q == ST_IDLE) begin
        idx_d = '0;
        cnt_d = '0;
      end else if (slot_end) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      state_d = ((GAP != 0) && (cnt_d < GAP_C)) ? ST_GAP : ST_SHOW;
    end

    // Outputs are computed from next-state values so they register on the same edge.
    if (state_d == ST_SHOW) begin
      com_d = DIGITS'(1) << idx_d;
      seg_d = {decode(shadow_din_d[{idx_d, 2'b00} +: 4]), shadow_dp_d[idx_d]};
    end

    frame_done_d = wrap;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      pend_din_q   <= '0;
      pend_dp_q    <= '0;
      // NOTE: the shadow/pending data registers are reset too, so the first frame shows zeros.
      shadow_din_q <= '0;
      shadow_dp_q  <= '0;
      seg_q        <= 8'd0;
      com_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      pend_din_q   <= pend_din_d;
      pend_dp_q    <= pend_dp_d;
      shadow_din_q <= shadow_din_d;
      shadow_dp_q  <= shadow_dp_d;
      seg_q        <= seg_d;
      com_q        <= com_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign com        = com_q;
  assign frame_done = frame_done_q;

endmodule
